// File: rtl/sub4_serial.sv
// Bit-serial subtractor: d = a - b (mod 2^WIDTH) with borrow out, one bit per clock LSB-first.
// Operands are captured on start, result and borrow are held until the next completion.
module sub4_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b4
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             br_next;
    logic [WIDTH-1:0] rr_next;

    // Full-subtractor slice on the current LSBs; rr fills from the top so the
    // first bit processed ends up in bit 0 after WIDTH shifts.
    always_comb begin
        x       = ra[0] ^ rb[0] ^ br;
        br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        rr_next = {x, rr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            b4    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rr  <= rr_next;
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        d     <= rr_next;
                        b4    <= br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub4_serial.sv
// Directed bench for sub4_serial: handshake timing, boundary operands, ignored starts,
// mid-operation reset and an exhaustive back-to-back sweep.
module tb_sub4_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       b4;

    int checks = 0;
    int passed = 0;

    sub4_serial #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b4    (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE, returning the result, edges from accept to done,
    // busy cycles seen and a timeout flag; ends one edge after done (back in IDLE).
    task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input bit scramble,
                         output logic [3:0] od, output logic ob4, output int lat,
                         output int bcnt, output bit tmo);
        a = ia;
        b = ib;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            if (scramble) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            step();
            lat++;
        end
        tmo = !done;
        od = d;
        ob4 = b4;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        #12;
        checks++;
        if ({busy, done, b4, d} !== 7'd0)
            $display("FAIL reset_state got busy=%b done=%b b4=%b d=%h expected all zero", busy, done, b4, d);
        else passed++;
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [3:0] od;
        logic ob4;
        int lat, bcnt;
        bit tmo;
        do_op(4'b1000, 4'b0101, 1'b0, od, ob4, lat, bcnt, tmo);
        checks++;
        if (tmo || od !== 4'b0011 || ob4 !== 1'b0)
            $display("FAIL basic_8m5 got d=%b b4=%b tmo=%0d expected d=0011 b4=0", od, ob4, tmo);
        else passed++;
        checks++;
        if (lat !== 4)
            $display("FAIL basic_latency got %0d edges after accept expected 4", lat);
        else passed++;
        checks++;
        if (bcnt !== 4)
            $display("FAIL basic_busy_cycles got %0d expected 4", bcnt);
        else passed++;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_done_pulse got done=%b busy=%b after pulse expected 0 0", done, busy);
        else passed++;
        checks++;
        if (d !== 4'b0011 || b4 !== 1'b0)
            $display("FAIL basic_hold got d=%b b4=%b expected d=0011 b4=0", d, b4);
        else passed++;
    endtask

    task automatic test_pairs();
        logic [3:0] ta [4] = '{4'd6, 4'd1, 4'd0, 4'd15};
        logic [3:0] tb [4] = '{4'd1, 4'd6, 4'd0, 4'd15};
        logic [3:0] td [4] = '{4'b0101, 4'b1011, 4'd0, 4'd0};
        logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] od;
        logic ob4;
        int lat, bcnt;
        bit tmo;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], 1'b0, od, ob4, lat, bcnt, tmo);
            checks++;
            if (tmo || od !== td[i] || ob4 !== tc[i])
                $display("FAIL pair_%0d a=%0d b=%0d got d=%b b4=%b tmo=%0d expected d=%b b4=%b",
                         i, ta[i], tb[i], od, ob4, tmo, td[i], tc[i]);
            else passed++;
        end
    endtask

    task automatic test_boundary();
        logic [3:0] ta [2] = '{4'd0, 4'd15};
        logic [3:0] tb [2] = '{4'd15, 4'd0};
        logic [3:0] td [2] = '{4'b0001, 4'd15};
        logic       tc [2] = '{1'b1, 1'b0};
        logic [3:0] od;
        logic ob4;
        int lat, bcnt;
        bit tmo;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], 1'b0, od, ob4, lat, bcnt, tmo);
            checks++;
            if (tmo || od !== td[i] || ob4 !== tc[i])
                $display("FAIL boundary_%0d a=%0d b=%0d got d=%b b4=%b tmo=%0d expected d=%b b4=%b",
                         i, ta[i], tb[i], od, ob4, tmo, td[i], tc[i]);
            else passed++;
        end
    endtask

    // Previous result is 15-0=15, b4=0; it must survive the whole RUN phase.
    task automatic test_start_ignored();
        int lat = 0;
        int pulses = 0;
        bit held_ok = 1'b1;
        a = 4'd8;
        b = 4'd5;
        start = 1'b1;
        step();
        a = 4'd2;
        b = 4'd7;
        while (!done && lat < 20) begin
            if (busy && (d !== 4'd15 || b4 !== 1'b0)) held_ok = 1'b0;
            if (lat == 2) start = 1'b0;
            step();
            lat++;
        end
        checks++;
        if (!held_ok)
            $display("FAIL ignore_hold_prev d changed during RUN expected d=15 b4=0 throughout");
        else passed++;
        checks++;
        if (!done || d !== 4'd3 || b4 !== 1'b0)
            $display("FAIL ignore_result got done=%b d=%0d b4=%b expected done=1 d=3 b4=0", done, d, b4);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0)
            $display("FAIL ignore_single_done got %0d extra done pulses expected 0", pulses);
        else passed++;
    endtask

    task automatic test_operand_change();
        logic [3:0] od;
        logic ob4;
        int lat, bcnt;
        bit tmo;
        do_op(4'd12, 4'd9, 1'b1, od, ob4, lat, bcnt, tmo);
        checks++;
        if (tmo || od !== 4'd3 || ob4 !== 1'b0)
            $display("FAIL opchange_12m9 got d=%0d b4=%b expected d=3 b4=0", od, ob4);
        else passed++;
        do_op(4'd3, 4'd10, 1'b1, od, ob4, lat, bcnt, tmo);
        checks++;
        if (tmo || od !== 4'd9 || ob4 !== 1'b1)
            $display("FAIL opchange_3m10 got d=%0d b4=%b expected d=9 b4=1", od, ob4);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] od;
        logic ob4;
        int lat, bcnt;
        bit tmo;
        bit quiet = 1'b1;
        a = 4'd13;
        b = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, b4, d} !== 7'd0)
            $display("FAIL midreset_clear got busy=%b done=%b b4=%b d=%0d expected all zero", busy, done, b4, d);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) quiet = 1'b0;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) quiet = 1'b0;
        end
        checks++;
        if (!quiet)
            $display("FAIL midreset_no_done got activity after abort expected done=0 busy=0");
        else passed++;
        do_op(4'd9, 4'd3, 1'b0, od, ob4, lat, bcnt, tmo);
        checks++;
        if (tmo || od !== 4'd6 || ob4 !== 1'b0)
            $display("FAIL midreset_9m3 got d=%0d b4=%b expected d=6 b4=0", od, ob4);
        else passed++;
    endtask

    // start stays high; next operands are presented between done and the re-accepting edge.
    task automatic test_back_to_back();
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] ed;
        int lat;
        a = 4'd0;
        b = 4'd0;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ea = 4'(i >> 4);
            eb = 4'(i);
            ed = ea - eb;
            step();
            lat = 0;
            while (!done && lat < 20) begin
                if (busy && done) lat = 99;
                step();
                lat++;
            end
            checks++;
            if (lat !== 4 || d !== ed || b4 !== (ea < eb))
                $display("FAIL b2b a=%0d b=%0d got d=%0d b4=%b lat=%0d expected d=%0d b4=%b lat=4",
                         ea, eb, d, b4, lat, ed, (ea < eb));
            else passed++;
            a = 4'((i + 1) >> 4);
            b = 4'(i + 1);
            step();
        end
        start = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pairs();
        test_boundary();
        test_start_ignored();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
